sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl_pkg.sv | 16 +
 rtl/sweep_pulse_qual.sv | 32 +++
 rtl/sweep_ctrl.sv | 151 +++++++++++++++
 tb/tb_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared types for the sweep controller: FSM state encoding and a state-class helper.
package sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    // True in the states where the downstream counter is being driven.
    function automatic logic is_busy(input state_e s);
        return (s == StLoad) || (s == StRun);
    endfunction

endpackage

// File: rtl/sweep_pulse_qual.sv
// Terminal-pulse qualifier: blanks the first RUN cycle and the cycle after each counted
// pulse, so a pulse held for two cycles is counted once.
module sweep_pulse_qual (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_abort,
    input  logic i_pulse,
    output logic o_counted
);

    logic r_blank;
    logic w_blank_d;

    // An abort outranks a same-cycle pulse, so such a pulse is never counted.
    assign o_counted = i_run & i_pulse & ~r_blank & ~i_abort;

    // Blanking is armed whenever we are outside RUN and for one cycle after a count.
    always_comb begin
        w_blank_d = ~i_run | o_counted;
    end

    // Blanking flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blank <= 1'b1;
        end else begin
            r_blank <= w_blank_d;
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequence controller driving an up/down counter with optional preload.
// Ping-pong direction reversal is built only when SWEEP_CTRL_PINGPONG_EN is defined.
module sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_in,
    input  logic             pingpong,
    input  logic [SIZE-1:0]  preload,
    input  logic [CNT_W-1:0] sweeps,
    input  logic             pulse,
    output logic             enable,
    output logic             up_down,
    output logic [SIZE-1:0]  load,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sweep_cnt
);

    state_e           r_state;
    state_e           w_state_d;
    logic             r_dir;
    logic [SIZE-1:0]  r_preload;
    logic [CNT_W-1:0] r_sweeps;
    logic [CNT_W-1:0] r_sweep_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_run;
    logic             w_counted;
    logic             w_start_ok;

`ifdef SWEEP_CTRL_PINGPONG_EN
    logic             r_pingpong;
`else
    logic             w_unused_pingpong;
    assign w_unused_pingpong = pingpong;
`endif

    assign w_run      = (r_state == StRun);
    assign w_start_ok = (r_state == StIdle) && start;
    assign w_cnt_inc  = r_sweep_cnt + CNT_W'(1);

    sweep_pulse_qual u_qual (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_run),
        .i_abort   (stop),
        .i_pulse   (pulse),
        .o_counted (w_counted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (sweeps == '0) begin
                        w_state_d = StDone;
                    end else if (preload != '0) begin
                        w_state_d = StLoad;
                    end else begin
                        w_state_d = StRun;
                    end
                end
            end
            StLoad: w_state_d = stop ? StIdle : StRun;
            StRun: begin
                if (stop) begin
                    w_state_d = StIdle;
                end else if (w_counted && (w_cnt_inc == r_sweeps)) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Captured sequence parameters, pulse counter and direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir       <= 1'b0;
            r_preload   <= '0;
            r_sweeps    <= '0;
            r_sweep_cnt <= '0;
`ifdef SWEEP_CTRL_PINGPONG_EN
            r_pingpong  <= 1'b0;
`endif
        end else begin
            if (w_start_ok) begin
                r_dir       <= dir_in;
                r_preload   <= preload;
                r_sweeps    <= sweeps;
                r_sweep_cnt <= '0;
`ifdef SWEEP_CTRL_PINGPONG_EN
                r_pingpong  <= pingpong;
`endif
            end
            // Saturate rather than wrap; a full-scale request ends before this matters.
            if (w_counted && (r_sweep_cnt != '1)) begin
                r_sweep_cnt <= w_cnt_inc;
            end
`ifdef SWEEP_CTRL_PINGPONG_EN
            if (w_counted && r_pingpong) begin
                r_dir <= ~r_dir;
            end
`endif
        end
    end

    // Moore output decode from registered state and captured values.
    always_comb begin
        enable  = 1'b0;
        up_down = 1'b0;
        load    = '0;
        busy    = is_busy(r_state);
        done    = 1'b0;
        unique case (r_state)
            StIdle: ;
            StLoad: begin
                enable  = 1'b1;
                up_down = r_dir;
                load    = r_preload;
            end
            StRun: begin
                enable  = 1'b1;
                up_down = r_dir;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: stimulus pushes expected load/done responses,
// a negedge monitor pops and compares them whenever the DUT presents load or done.
module tb_sweep_ctrl;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             dir_in;
    logic             pingpong;
    logic [SIZE-1:0]  preload;
    logic [CNT_W-1:0] sweeps;
    logic             pulse;
    logic             enable;
    logic             up_down;
    logic [SIZE-1:0]  load;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sweep_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // {up_down, load} expected while load is nonzero; sweep_cnt expected at done.
    logic [SIZE:0]    q_load[$];
    logic [CNT_W-1:0] q_done[$];

    sweep_ctrl #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .dir_in    (dir_in),
        .pingpong  (pingpong),
        .preload   (preload),
        .sweeps    (sweeps),
        .pulse     (pulse),
        .enable    (enable),
        .up_down   (up_down),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .sweep_cnt (sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a load or a done strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (load != '0) begin
                if (q_load.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: got 0x%0h expected none", load);
                end else begin
                    chk("load_bus", {23'd0, up_down, load}, {23'd0, q_load.pop_front()});
                end
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: sweep_cnt 0x%0h expected no done", sweep_cnt);
                end else begin
                    chk("done_cnt", {24'd0, sweep_cnt}, {24'd0, q_done.pop_front()});
                    chk("done_enable", {31'd0, enable}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [SIZE-1:0] pre, input logic dir, input logic pp,
                         input logic [CNT_W-1:0] n);
        preload  = pre;
        dir_in   = dir;
        pingpong = pp;
        sweeps   = n;
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_enable"}, {31'd0, enable}, 32'd0);
        chk({tag, "_up_down"}, {31'd0, up_down}, 32'd0);
        chk({tag, "_load"}, {24'd0, load}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, sweep_cnt}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; dir_in = 1'b0; pingpong = 1'b0;
        preload = '0; sweeps = '0; pulse = 1'b0;
        cyc(2);
        check_idle_outputs("reset");
        reset = 1'b0;
        cyc(1);

        // Preloaded single sweep: LOAD 0xFC, first RUN pulse blanked, then counted.
        q_load.push_back({1'b1, 8'hFC});
        q_done.push_back(8'd1);
        issue(8'hFC, 1'b1, 1'b0, 8'd1);
        chk("t1_load_enable", {31'd0, enable}, 32'd1);
        chk("t1_load_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        chk("t1_run_load", {24'd0, load}, 32'd0);
        chk("t1_run_updown", {31'd0, up_down}, 32'd1);
        pulse = 1'b1;
        cyc(1);
        chk("t1_blank_cnt", {24'd0, sweep_cnt}, 32'd0);
        chk("t1_blank_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        pulse = 1'b0;
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);
        cyc(1);
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);

        // No preload, two sweeps down: LOAD skipped.
        q_done.push_back(8'd2);
        issue(8'h00, 1'b0, 1'b0, 8'd2);
        chk("t2_run_busy", {31'd0, busy}, 32'd1);
        chk("t2_run_enable", {31'd0, enable}, 32'd1);
        cyc(1);
        pulse = 1'b1; cyc(1); pulse = 1'b0;
        chk("t2_cnt1", {24'd0, sweep_cnt}, 32'd1);
        chk("t2_still_run", {31'd0, busy}, 32'd1);
        cyc(1);
        pulse = 1'b1; cyc(1); pulse = 1'b0;
        chk("t2_done", {31'd0, done}, 32'd1);
        cyc(1);
        chk("t2_cnt_hold", {24'd0, sweep_cnt}, 32'd2);

        // Ping-pong request; pulse held two cycles counts once.
        q_load.push_back({1'b1, 8'hFE});
        q_done.push_back(8'd2);
        issue(8'hFE, 1'b1, 1'b1, 8'd2);
        cyc(2);
        pulse = 1'b1; cyc(1);
`ifdef SWEEP_CTRL_PINGPONG_EN
        chk("t3_dir_toggled", {31'd0, up_down}, 32'd0);
`else
        chk("t3_dir_fixed", {31'd0, up_down}, 32'd1);
`endif
        cyc(1); pulse = 1'b0;
        chk("t3_held_once", {24'd0, sweep_cnt}, 32'd1);
        cyc(1);
        pulse = 1'b1; cyc(1); pulse = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_cnt", {24'd0, sweep_cnt}, 32'd2);
        cyc(1);

        // Stop coincident with the final pulse: abort, no done.
        issue(8'h00, 1'b1, 1'b0, 8'd1);
        cyc(1);
        pulse = 1'b1; stop = 1'b1; cyc(1); pulse = 1'b0; stop = 1'b0;
        chk("t4_enable", {31'd0, enable}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_cnt", {24'd0, sweep_cnt}, 32'd0);
        cyc(2);
        chk("t4_no_done", {31'd0, done}, 32'd0);

        // Reset mid-RUN at sweep_cnt=3, then a normal sequence.
        issue(8'h00, 1'b1, 1'b0, 8'd5);
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            pulse = 1'b1; cyc(1); pulse = 1'b0; cyc(1);
        end
        chk("t5_cnt3", {24'd0, sweep_cnt}, 32'd3);
        reset = 1'b1; cyc(1);
        check_idle_outputs("t5_reset");
        reset = 1'b0;
        q_load.push_back({1'b0, 8'h11});
        q_done.push_back(8'd1);
        issue(8'h11, 1'b0, 1'b0, 8'd1);
        cyc(2);
        pulse = 1'b1; cyc(1); pulse = 1'b0;
        chk("t5_done", {31'd0, done}, 32'd1);
        cyc(1);

        // Zero sweeps: DONE straight from IDLE.
        q_done.push_back(8'd0);
        issue(8'h33, 1'b1, 1'b0, 8'd0);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_enable", {31'd0, enable}, 32'd0);
        cyc(1);
        chk("t6_idle", {31'd0, busy | done | enable}, 32'd0);

        cyc(2);
        chk("q_load_drained", q_load.size(), 32'd0);
        chk("q_done_drained", q_done.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
